// File: rtl/adj_mod_counter.sv
// adj_mod_counter
// Modulo counter for one clock/calendar digit field with a range of [MIN, MAX].
// It has three ways to change the count:
//   - a synchronous load, clamped to the legal range,
//   - manual +1/-1 steps from the adjust buttons, with hold-to-repeat,
//   - an enable tick that counts up or down and produces carry/borrow
//     pulses for chaining to the next digit.
// Priority on each CP edge is load > manual step > EN count > hold.
//
// Ports:
//   CP          clock, rising edge
//   reset       asynchronous reset, active low
//   EN          count enable tick (one CP cycle wide)
//   dir         EN count direction: 0 = up, 1 = down
//   load        synchronous load strobe
//   load_val    value to load (out-of-range values load MIN)
//   inc_btn     increment button level, asynchronous to CP
//   dec_btn     decrement button level, asynchronous to CP
//   rpt_tick    prescaled timing pulse driving the repeat timing
//   Q           registered count value
//   carry       one-cycle pulse while Q shows an EN-caused MAX->MIN wrap
//   borrow      one-cycle pulse while Q shows an EN-caused MIN->MAX wrap
//   adj_active  high while the repeat FSM is not idle
module adj_mod_counter #(
   parameter int WIDTH     = 4,
   parameter int MIN       = 0,
   parameter int MAX       = 5,
   parameter int RPT_DELAY = 4,
   parameter int RPT_RATE  = 2
) (
   input  logic             CP,
   input  logic             reset,
   input  logic             EN,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc_btn,
   input  logic             dec_btn,
   input  logic             rpt_tick,
   output logic [WIDTH-1:0] Q,
   output logic             carry,
   output logic             borrow,
   output logic             adj_active
);

   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] SPAN  = WIDTH'(MAX - MIN);

   localparam int RMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
   localparam logic [RW-1:0] DLY_LAST  = RW'(RPT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST = RW'(RPT_RATE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   // ---------------------------------------------------------------
   // Button synchronizers
   // ---------------------------------------------------------------
   logic [1:0] inc_sync_q, dec_sync_q;
   // Goes to all-ones two edges after reset. That is when the
   // synchronizer outputs first reflect the real button levels.
   logic [1:0] sync_vld_q;
   logic       btn_prev_q;
   logic       inc_s, dec_s, btn, btn_rise;

   assign inc_s = inc_sync_q[1];
   assign dec_s = dec_sync_q[1];
   assign btn   = inc_s ^ dec_s;

   // btn_prev_q comes out of reset high and is frozen until the
   // synchronizers have settled. As a result, a button that is still
   // held through reset is not treated as a new press. It must be
   // released and pressed again.
   assign btn_rise = btn & ~btn_prev_q;

   always_ff @(posedge CP or negedge reset) begin
      if (!reset) begin
         inc_sync_q <= '0;
         dec_sync_q <= '0;
         sync_vld_q <= '0;
         btn_prev_q <= 1'b1;
      end else begin
         inc_sync_q <= {inc_sync_q[0], inc_btn};
         dec_sync_q <= {dec_sync_q[0], dec_btn};
         sync_vld_q <= {sync_vld_q[0], 1'b1};
         if (sync_vld_q[1]) btn_prev_q <= btn;
      end
   end

   // ---------------------------------------------------------------
   // Repeat FSM
   // ---------------------------------------------------------------
   state_t        state_q, state_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          step;

   always_ff @(posedge CP or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      step    = 1'b0;
      if (!btn) begin
         // Covers release and both-buttons-held.
         state_d = S_IDLE;
         rcnt_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (btn_rise) begin
                  step    = 1'b1;
                  state_d = S_WAIT;
                  rcnt_d  = '0;
               end
            end
            S_WAIT: begin
               if (rpt_tick) begin
                  if (rcnt_q == DLY_LAST) begin
                     step    = 1'b1;
                     state_d = S_REPEAT;
                     rcnt_d  = '0;
                  end else begin
                     rcnt_d = rcnt_q + 1'b1;
                  end
               end
            end
            S_REPEAT: begin
               if (rpt_tick) begin
                  if (rcnt_q == RATE_LAST) begin
                     step   = 1'b1;
                     rcnt_d = '0;
                  end else begin
                     rcnt_d = rcnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               rcnt_d  = '0;
            end
         endcase
      end
   end

   assign adj_active = (state_q != S_IDLE);

   // ---------------------------------------------------------------
   // Count datapath
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] q_q, q_d, q_up, q_dn, lv_off;
   logic             carry_q, carry_d, borrow_q, borrow_d;

   assign q_up = (q_q == MAX_V) ? MIN_V : q_q + 1'b1;
   assign q_dn = (q_q == MIN_V) ? MAX_V : q_q - 1'b1;

   // Range check via wrapped offset. Values below MIN wrap to a large
   // offset, so a single compare covers both bounds.
   assign lv_off = load_val - MIN_V;

   always_comb begin
      q_d      = q_q;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      if (load) begin
         q_d = (lv_off <= SPAN) ? load_val : MIN_V;
      end else if (step) begin
         // Exactly one synchronized button is high whenever step fires.
         q_d = inc_s ? q_up : q_dn;
      end else if (EN) begin
         if (!dir) begin
            q_d     = q_up;
            carry_d = (q_q == MAX_V);
         end else begin
            q_d      = q_dn;
            borrow_d = (q_q == MIN_V);
         end
      end
   end

   always_ff @(posedge CP or negedge reset) begin
      if (!reset) begin
         q_q      <= MIN_V;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         q_q      <= q_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
      end
   end

   assign Q      = q_q;
   assign carry  = carry_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_adj_mod_counter.sv
module tb_adj_mod_counter;
   localparam int W = 4;
   localparam int D = 4;
   localparam int R = 2;

   logic         CP = 1'b0;
   logic         reset, EN, dir, load, inc_btn, dec_btn, rpt_tick;
   logic [W-1:0] load_val;
   logic [W-1:0] q0, q1;
   logic         c0, b0, a0, c1, b1, a1;

   always #5 CP = ~CP;

   adj_mod_counter #(.WIDTH(W), .MIN(0), .MAX(5), .RPT_DELAY(D), .RPT_RATE(R)) u0 (
      .CP(CP), .reset(reset), .EN(EN), .dir(dir), .load(load), .load_val(load_val),
      .inc_btn(inc_btn), .dec_btn(dec_btn), .rpt_tick(rpt_tick),
      .Q(q0), .carry(c0), .borrow(b0), .adj_active(a0));

   adj_mod_counter #(.WIDTH(W), .MIN(1), .MAX(12), .RPT_DELAY(D), .RPT_RATE(R)) u1 (
      .CP(CP), .reset(reset), .EN(EN), .dir(dir), .load(load), .load_val(load_val),
      .inc_btn(inc_btn), .dec_btn(dec_btn), .rpt_tick(rpt_tick),
      .Q(q1), .carry(c1), .borrow(b1), .adj_active(a1));

   int total = 0;
   int bad   = 0;

   // Reference model state
   int mk;             // edges since reset release
   bit i1, i2, d1, d2; // raw button levels seen 1 and 2 edges ago
   bit bprev;          // pressed-level at the previous edge
   bit held;           // a press is being tracked
   int ticks;          // rpt_ticks seen since the first step of this press
   int mq0, mq1;
   bit mc0, mb0, mc1, mb1, madj;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mk = 0; i1 = 0; i2 = 0; d1 = 0; d2 = 0; bprev = 1; held = 0; ticks = 0;
      mq0 = 0; mq1 = 1; mc0 = 0; mb0 = 0; mc1 = 0; mb1 = 0; madj = 0;
   endtask

   task automatic model_q(inout int q, output bit c, output bit b,
                          input int lo, input int hi, input bit stp, input bit up);
      int n;
      n = hi - lo + 1;
      c = 0; b = 0;
      if (load) begin
         q = (int'(load_val) >= lo && int'(load_val) <= hi) ? int'(load_val) : lo;
      end else if (stp) begin
         q = lo + ((q - lo + (up ? 1 : n - 1)) % n);
      end else if (EN) begin
         if (!dir) begin
            c = (q == hi);
            q = lo + ((q - lo + 1) % n);
         end else begin
            b = (q == lo);
            q = lo + ((q - lo + n - 1) % n);
         end
      end
   endtask

   task automatic model_edge();
      bit incs, decs, pressed, rise, stp;
      mk++;
      incs    = (mk >= 3) ? i2 : 1'b0;
      decs    = (mk >= 3) ? d2 : 1'b0;
      pressed = incs ^ decs;
      // The first settled sample after reset cannot count as a new press.
      rise    = pressed && (mk >= 4) && !bprev;
      stp     = 0;
      if (!pressed) held = 0;
      else if (!held) begin
         if (rise) begin stp = 1; held = 1; ticks = 0; end
      end else if (rpt_tick) begin
         ticks++;
         if (ticks >= D && ((ticks - D) % R) == 0) stp = 1;
      end
      model_q(mq0, mc0, mb0, 0, 5, stp, incs);
      model_q(mq1, mc1, mb1, 1, 12, stp, incs);
      madj  = held;
      bprev = pressed;
      i2 = i1; i1 = inc_btn;
      d2 = d1; d1 = dec_btn;
   endtask

   task automatic check_all();
      chk("q0", int'(q0), mq0);
      chk("carry0", int'(c0), int'(mc0));
      chk("borrow0", int'(b0), int'(mb0));
      chk("q1", int'(q1), mq1);
      chk("carry1", int'(c1), int'(mc1));
      chk("borrow1", int'(b1), int'(mb1));
      chk("adj0", int'(a0), int'(madj));
      chk("adj1", int'(a1), int'(madj));
   endtask

   // One clock edge: model advances, outputs checked 1 time unit later.
   task automatic cyc();
      @(posedge CP);
      model_edge();
      #1;
      check_all();
   endtask

   // Reset pulse placed mid-cycle. Q must reach MIN without waiting for a clock.
   task automatic do_reset();
      #2 reset = 1'b0;
      #1;
      model_reset();
      chk("rst_q0_async", int'(q0), 0);
      chk("rst_q1_async", int'(q1), 1);
      check_all();
      @(posedge CP);
      @(posedge CP);
      #3 reset = 1'b1;
   endtask

   task automatic run(input int n, input int tick_period);
      for (int k = 0; k < n; k++) begin
         rpt_tick = (tick_period > 0) && (k % tick_period == tick_period - 1);
         cyc();
      end
      rpt_tick = 1'b0;
   endtask

   initial begin
      int seq[7];
      int tickn;
      seq = '{1, 2, 3, 4, 5, 0, 1};
      reset = 1'b0; EN = 0; dir = 0; load = 0; load_val = '0;
      inc_btn = 0; dec_btn = 0; rpt_tick = 0;
      model_reset();
      @(posedge CP); @(posedge CP);
      #1;
      chk("reset_q0", int'(q0), 0);
      chk("reset_q1", int'(q1), 1);
      check_all();
      #2 reset = 1'b1;

      // Count up through the MAX->MIN wrap
      run(2, 0);
      EN = 1; dir = 0;
      for (int k = 0; k < 7; k++) begin
         cyc();
         chk("plan_up_q", int'(q0), seq[k]);
         chk("plan_up_carry", int'(c0), (seq[k] == 0) ? 1 : 0);
      end
      EN = 0;

      // Load 0, then count down through the MIN->MAX wrap
      load = 1; load_val = 4'd0; cyc(); load = 0;
      EN = 1; dir = 1; cyc(); EN = 0;
      chk("plan_dn_q", int'(q0), 5);
      chk("plan_dn_borrow", int'(b0), 1);
      EN = 1; cyc(); EN = 0;
      chk("plan_dn2_q", int'(q0), 4);
      chk("plan_dn2_borrow", int'(b0), 0);
      dir = 0;

      // Out-of-range load, load beats EN, then EN wrap on the 1..12 field
      load = 1; load_val = 4'd13; cyc();
      chk("plan_ld13", int'(q1), 1);
      load_val = 4'd12; EN = 1; cyc(); load = 0;
      chk("plan_ld12", int'(q1), 12);
      chk("plan_ld12_carry", int'(c1), 0);
      cyc(); EN = 0;
      chk("plan_wrap12", int'(q1), 1);
      chk("plan_wrap12_carry", int'(c1), 1);

      // Hold-to-repeat starting from 3
      load = 1; load_val = 4'd3; cyc(); load = 0;
      inc_btn = 1;
      cyc(); cyc();
      chk("plan_press_lat_q", int'(q0), 3);
      cyc();
      chk("plan_first_step", int'(q0), 4);
      tickn = 0;
      for (int k = 0; k < 120; k++) begin
         rpt_tick = (k % 10 == 9);
         cyc();
         if (rpt_tick) begin
            tickn++;
            if (tickn == 4) chk("plan_tick4", int'(q0), 5);
            if (tickn == 6) begin
               chk("plan_tick6", int'(q0), 0);
               chk("plan_tick6_carry", int'(c0), 0);
            end
         end
      end
      rpt_tick = 0;
      inc_btn = 0;
      run(5, 0);
      chk("plan_release_adj", int'(a0), 0);

      // Both buttons at once count as no press
      load = 1; load_val = 4'd2; cyc(); load = 0;
      inc_btn = 1; dec_btn = 1;
      run(30, 5);
      chk("plan_both_q", int'(q0), 2);
      chk("plan_both_adj", int'(a0), 0);
      EN = 1; run(3, 0); EN = 0;
      chk("plan_both_en", int'(q0), 5);
      inc_btn = 0; dec_btn = 0;
      run(4, 0);

      // Reset while repeating with the button still held
      dec_btn = 1;
      run(60, 10);
      chk("plan_rpt_active", int'(a0), 1);
      do_reset();
      run(60, 10);
      chk("plan_post_rst_q", int'(q0), 0);
      chk("plan_post_rst_adj", int'(a0), 0);
      dec_btn = 0; run(4, 0);
      dec_btn = 1; run(4, 0);
      chk("plan_repress_q", int'(q0), 5);
      dec_btn = 0; run(4, 0);

      // Random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         EN       = ($urandom_range(2, 0) == 0);
         dir      = $urandom_range(1, 0) == 1;
         load     = ($urandom_range(15, 0) == 0);
         load_val = W'($urandom_range(15, 0));
         rpt_tick = ($urandom_range(2, 0) == 0);
         if ($urandom_range(19, 0) == 0) begin
            inc_btn = $urandom_range(1, 0) == 1;
            dec_btn = $urandom_range(1, 0) == 1;
         end
         if ($urandom_range(999, 0) == 0) do_reset();
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
